// File: rtl/tl_pkg.sv
// Shared types for the two-road traffic light controller: the phase
// enumeration, the lamp codes driven to the LED drivers, and the decoder
// from (phase, flash phase) to the lamp pair {light_a, light_b}.
package tl_pkg;

   typedef enum logic [2:0] {
      A_GREEN   = 3'd0,
      A_YELLOW  = 3'd1,
      ALLRED_AB = 3'd2,
      B_GREEN   = 3'd3,
      B_YELLOW  = 3'd4,
      ALLRED_BA = 3'd5,
      FLASH     = 3'd6
   } tl_state_e;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b101;
   localparam logic [2:0] GREEN  = 3'b001;
   localparam logic [2:0] OFF    = 3'b000;

   // Lamp pair for a phase; FLASH blinks both roads yellow in step.
   function automatic logic [5:0] lamps(input tl_state_e state, input logic flash_on);
      logic [5:0] l;
      case (state)
         A_GREEN:   l = {GREEN,  RED};
         A_YELLOW:  l = {YELLOW, RED};
         ALLRED_AB: l = {RED,    RED};
         B_GREEN:   l = {RED,    GREEN};
         B_YELLOW:  l = {RED,    YELLOW};
         ALLRED_BA: l = {RED,    RED};
         FLASH:     l = flash_on ? {YELLOW, YELLOW} : {OFF, OFF};
         default:   l = {RED,    RED};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_param.sv
// Two-road intersection controller with parametrised phase lengths,
// all-red clearance, latched pedestrian request (shortens green) and a
// night flashing-yellow mode. The phase FSM advances only on cycles with
// tick=1, supplied by a divider elsewhere on the board.
// Optional build macro TL_COUNTDOWN_EN adds the 'remain' countdown output.
module traffic_light_ctrl_param
   import tl_pkg::*;
#(
   parameter int CNT_W           = 8,
   parameter int GREEN_TICKS     = 6,
   parameter int YELLOW_TICKS    = 4,
   parameter int ALLRED_TICKS    = 1,
   parameter int MIN_GREEN_TICKS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             mode_flash,
   input  logic             ped_req,
   output logic [2:0]       light_a,
   output logic [2:0]       light_b
`ifdef TL_COUNTDOWN_EN
   ,
   output logic [CNT_W-1:0] remain
`endif
);

   localparam logic [CNT_W-1:0] GREEN_M1  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GREEN_TICKS - 1);

   tl_state_e        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             ped_pend, ped_pend_n;
   logic             flash_on, flash_on_n;

   // Last count value of a phase (duration minus one).
   function automatic logic [CNT_W-1:0] dur_m1(input tl_state_e s);
      case (s)
         A_GREEN, B_GREEN:     return GREEN_M1;
         A_YELLOW, B_YELLOW:   return YELLOW_M1;
         ALLRED_AB, ALLRED_BA: return ALLRED_M1;
         default:              return '0;
      endcase
   endfunction

   // Successor in the normal rotation.
   function automatic tl_state_e succ(input tl_state_e s);
      case (s)
         A_GREEN:   return A_YELLOW;
         A_YELLOW:  return ALLRED_AB;
         ALLRED_AB: return B_GREEN;
         B_GREEN:   return B_YELLOW;
         B_YELLOW:  return ALLRED_BA;
         default:   return A_GREEN;
      endcase
   endfunction

   // Next phase, count, flash phase and pending request; flash handling
   // outranks pedestrian shortening, which outranks normal counting.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      flash_on_n = flash_on;
      ped_pend_n = ped_pend | ped_req;
      if (tick) begin
         if (state != FLASH && mode_flash) begin
            state_n    = FLASH;
            cnt_n      = '0;
            flash_on_n = 1'b1;
         end else if (state == FLASH) begin
            if (!mode_flash) begin
               state_n    = ALLRED_BA;
               cnt_n      = '0;
               flash_on_n = 1'b0;
            end else begin
               flash_on_n = ~flash_on;
            end
         end else if (ped_pend && (state == A_GREEN || state == B_GREEN) && cnt >= MIN_M1) begin
            state_n = succ(state);
            cnt_n   = '0;
         end else if (cnt == dur_m1(state)) begin
            state_n = succ(state);
            cnt_n   = '0;
         end else begin
            cnt_n = cnt + CNT_W'(1);
         end
      end
      // A request is served by the yellow that follows it; entering
      // yellow or flash discards it, even against a same-cycle request.
      if (state_n != state &&
          (state_n == A_YELLOW || state_n == B_YELLOW || state_n == FLASH))
         ped_pend_n = 1'b0;
   end

   // State register with synchronous reset to the start of A green.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= A_GREEN;
         cnt      <= '0;
         ped_pend <= 1'b0;
         flash_on <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         ped_pend <= ped_pend_n;
         flash_on <= flash_on_n;
      end
   end

   assign {light_a, light_b} = lamps(state, flash_on);

`ifdef TL_COUNTDOWN_EN
   assign remain = (state == FLASH) ? '0 : dur_m1(state) - cnt;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Directed bench for traffic_light_ctrl_param with default parameters.
module tb_traffic_light_ctrl_param;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b101;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] O = 3'b000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       mode_flash = 1'b0;
   logic       ped_req = 1'b0;
   logic [2:0] light_a;
   logic [2:0] light_b;
`ifdef TL_COUNTDOWN_EN
   logic [7:0] remain;
`endif

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic       r;
      logic       t;
      logic       m;
      logic       p;
      int         n;
      logic [2:0] ea;
      logic [2:0] eb;
      string      name;
   } vec_t;

   vec_t vecs[$];

   traffic_light_ctrl_param dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .mode_flash (mode_flash),
      .ped_req    (ped_req),
      .light_a    (light_a),
      .light_b    (light_b)
`ifdef TL_COUNTDOWN_EN
      ,
      .remain     (remain)
`endif
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, t, m, p, input int n,
                      input logic [2:0] ea, eb, input string name);
      vec_t v;
      v.r = r; v.t = t; v.m = m; v.p = p; v.n = n;
      v.ea = ea; v.eb = eb; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, t, m, p);
      rst = r; tick = t; mode_flash = m; ped_req = p;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [2:0] ea, eb);
      n_total++;
      if (light_a === ea && light_b === eb)
         n_pass++;
      else
         $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b",
                  name, light_a, light_b, ea, eb);
   endtask

`ifdef TL_COUNTDOWN_EN
   task automatic check_rem(input string name, input logic [7:0] er);
      n_total++;
      if (remain === er)
         n_pass++;
      else
         $display("FAIL %s: got remain=%0d, expected %0d", name, remain, er);
   endtask
`endif

   initial begin
      // reset overrides all inputs, then one full 22-tick rotation
      add(1,1,1,1, 1, G,R, "reset");
      add(0,1,0,0, 5, G,R, "a_green");
      add(0,1,0,0, 4, Y,R, "a_yellow");
      add(0,1,0,0, 1, R,R, "allred_ab");
      add(0,1,0,0, 6, R,G, "b_green");
      add(0,1,0,0, 4, R,Y, "b_yellow");
      add(0,1,0,0, 1, R,R, "allred_ba");
      add(0,1,0,0, 1, G,R, "wrap_a_green");
      // pedestrian pulse at cnt=0 shortens A green to two ticks
      add(0,1,0,1, 1, G,R, "ped0_green");
      add(0,1,0,0, 1, Y,R, "ped0_yellow");
      // request raised in yellow is carried to B green
      add(0,1,0,1, 1, Y,R, "ped_in_yellow");
      add(0,1,0,0, 2, Y,R, "yellow_rest");
      add(0,1,0,0, 1, R,R, "allred_ab2");
      add(0,1,0,0, 2, R,G, "b_green_short");
      add(0,1,0,0, 4, R,Y, "b_yellow2");
      add(0,1,0,0, 1, R,R, "allred_ba2");
      add(0,1,0,0, 1, G,R, "a_green2");
      // request at cnt=4
      add(0,1,0,0, 4, G,R, "a_green_cnt4");
      add(0,1,0,1, 1, G,R, "ped4_green");
      add(0,1,0,0, 4, Y,R, "ped4_yellow");
      add(0,1,0,0, 1, R,R, "allred_ab3");
      add(0,1,0,0, 4, R,G, "b_green_full");
      // flash entry from B green cnt=3, blink, exit via all-red
      add(0,1,1,0, 1, Y,Y, "flash_on1");
      add(0,1,1,0, 1, O,O, "flash_off1");
      add(0,1,1,0, 1, Y,Y, "flash_on2");
      add(0,1,1,0, 1, O,O, "flash_off2");
      add(0,1,0,0, 1, R,R, "flash_exit");
      add(0,1,0,0, 1, G,R, "after_flash");
      // no tick: mode_flash ignored, count holds
      add(0,0,1,0, 3, G,R, "hold_no_tick");
      add(0,1,0,0, 5, G,R, "green_after_hold");
      add(0,1,0,0, 1, Y,R, "yellow_after_hold");

      for (int i = 0; i < vecs.size(); i++)
         for (int j = 0; j < vecs[i].n; j++) begin
            drive(vecs[i].r, vecs[i].t, vecs[i].m, vecs[i].p);
            check(vecs[i].name, vecs[i].ea, vecs[i].eb);
         end

      // reset during yellow with tick=0 clears count and pending request
      drive(1,0,0,0);
      for (int k = 0; k < 6; k++) drive(0,1,0,0);
      check("seq_rst_yellow", Y, R);
      drive(0,0,0,1);
      check("seq_ped_no_tick", Y, R);
      drive(1,0,0,0);
      check("seq_rst_mid", G, R);
      for (int k = 0; k < 5; k++) begin
         drive(0,1,0,0);
         check("seq_green_unshortened", G, R);
      end
      drive(0,1,0,0);
      check("seq_yellow_after_rst", Y, R);

      // tick stalled in B green with toggling request
      drive(1,0,0,0);
      for (int k = 0; k < 11; k++) drive(0,1,0,0);
      check("seq_b_green", R, G);
      for (int k = 0; k < 10; k++) begin
         drive(0,0,0,k[0]);
         check("seq_stall", R, G);
      end
      drive(0,1,0,0);
      check("seq_resume_green", R, G);
      drive(0,1,0,0);
      check("seq_resume_yellow", R, Y);

`ifdef TL_COUNTDOWN_EN
      begin
         logic [7:0] exp_rem [10];
         exp_rem = '{8'd4,8'd3,8'd2,8'd1,8'd0,8'd3,8'd2,8'd1,8'd0,8'd0};
         drive(1,0,0,0);
         check_rem("rem_reset", 8'd5);
         for (int k = 0; k < 9; k++) begin
            drive(0,1,0,0);
            check_rem("rem_seq", exp_rem[k]);
         end
         drive(0,1,1,0);
         check_rem("rem_flash", exp_rem[9]);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl_param.md
Name: traffic_light_ctrl_param

Overview:
Parametrised two-road intersection controller, successor to the fixed four-phase cross-traffic light.
- Phase durations set by parameters.
- Adds all-red clearance phases, a latched pedestrian request that shortens green, and a night flashing-yellow mode.
- Advances on a one-cycle tick enable from a separate divider rather than on a derived clock.
- Sits between the board clock divider and the LED drivers of roads A and B.

Parameters:
- CNT_W, 8: phase counter width; all durations must be < 2**CNT_W.
- GREEN_TICKS, 6: green duration in ticks, ≥1.
- YELLOW_TICKS, 4: yellow duration in ticks, ≥1.
- ALLRED_TICKS, 1: all-red clearance duration in ticks, ≥1.
- MIN_GREEN_TICKS, 2: minimum green when a pedestrian request is pending; 1 ≤ MIN_GREEN_TICKS ≤ GREEN_TICKS.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- tick  input  1  one-cycle enable; the phase FSM advances only on edges where tick=1
- mode_flash  input  1  level; 1 requests flashing-yellow mode
- ped_req  input  1  pedestrian request pulse or level; sampled every cycle
- light_a  output  3  road A lamp code
- light_b  output  3  road B lamp code

Behaviour:
- Reset: one clock (clk); reset is synchronous and active-high.
  - On a clk edge with rst=1: state=A_GREEN, cnt=0, ped_pend=0, flash_on=0.
  - Outputs then read light_a=GREEN, light_b=RED.
  - rst overrides tick, mode_flash and ped_req in the same cycle, and aborts any phase mid-count.
- Lamp codes: RED=3'b100, YELLOW=3'b101, GREEN=3'b001, OFF=3'b000.
  - Lamps are decoded only from registered state/flash_on; there is no combinational input→output path.
- States and lamps (A/B):
  - A_GREEN (GREEN/RED)
  - A_YELLOW (YELLOW/RED)
  - ALLRED_AB (RED/RED)
  - B_GREEN (RED/GREEN)
  - B_YELLOW (RED/YELLOW)
  - ALLRED_BA (RED/RED)
  - FLASH (both YELLOW if flash_on=1, else both OFF)
- Normal sequence: A_GREEN→A_YELLOW→ALLRED_AB→B_GREEN→B_YELLOW→ALLRED_BA→A_GREEN.
- Counting, on a tick:
  - If cnt==DUR-1: advance to the next state and set cnt=0.
  - Otherwise: cnt=cnt+1.
  - Each phase therefore lasts exactly DUR ticks. Default full cycle = 2×(6+4+1) = 22 ticks.
- No tick: state, cnt and flash_on hold.
- Pedestrian request:
  - ped_pend is set on any cycle with ped_req=1.
  - While ped_pend=1 in A_GREEN or B_GREEN: advance to yellow on the first tick where cnt ≥ MIN_GREEN_TICKS-1.
  - ped_pend clears on entry to any YELLOW or to FLASH. Clear wins over a simultaneous ped_req.
  - A request raised during yellow or all-red stays pending and applies to the next green.
- Flash entry: a tick with mode_flash=1 in any non-FLASH state → FLASH, cnt=0, flash_on=1.
- In FLASH: each tick toggles flash_on.
- Flash exit: a tick with mode_flash=0 while in FLASH → ALLRED_BA, cnt=0, flash_on=0. After ALLRED_TICKS the controller reaches A_GREEN.
- Priority per tick: rst > flash entry/exit > pedestrian shortening > normal count.

Optional Feature:
- Macro: TL_COUNTDOWN_EN.
- Defined: adds output port remain [CNT_W-1:0] = DUR-1-cnt for the current phase (ticks left after this one), driving a 7-segment countdown display.
  - remain=0 in FLASH and after reset it equals GREEN_TICKS-1.
  - Pedestrian shortening does not alter remain's formula.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package tl_pkg holds:
  - the state enum (7 values, 3 bits);
  - the lamp-code constants RED/YELLOW/GREEN/OFF;
  - a function lamps(state, flash_on) returning {light_a, light_b}.
- One natural sub-module: tick_gen (parameter DIV) producing the one-cycle tick from clk with synchronous rst. It is instantiated at board top, not inside this block.

Test Plan:
All scenarios use default parameters and tick=1 every cycle unless stated.
- Reset, run 22 ticks → A GREEN for 6 ticks, YELLOW 4, RED/RED 1, B GREEN 6, B YELLOW 4, RED/RED 1, then back to A GREEN at tick 22.
- ped_req pulse at A_GREEN cnt=0 → A_YELLOW entered after tick 2. ped_req at cnt=4 → A_YELLOW on the next tick. ped_req during A_YELLOW → B_GREEN lasts 2 ticks.
- mode_flash=1 at B_GREEN cnt=3 → next tick both lamps 101, then 000, alternating each tick. mode_flash=0 → one tick RED/RED, then A GREEN.
- rst=1 for one cycle during A_YELLOW with tick=0 → next edge A=001, B=100, cnt=0. Pending ped_req is cleared.
- tick held 0 for 10 cycles in B_GREEN with ped_req toggling → lamps unchanged, ped_pend=1. Once tick resumes, B_YELLOW is entered at cnt ≥ 1.
- With TL_COUNTDOWN_EN: remain reads 5,4,3,2,1,0 across A_GREEN, then 3,2,1,0 across A_YELLOW.
